// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO sequencing controller for the EXE stage.
// Issues MULT/MULTU to a pipelined multiplier (fixed MUL_LAT latency) and
// DIV/DIVU to an iterative divider (held running by div_start until a
// div_complete pulse), stalls EXE while either is in flight, commits the
// result to HI/LO, and handles MTHI/MTLO/MFHI/MFLO. A flush from a later
// stage abandons any in-flight operation without touching HI/LO.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   es_valid, es_op     EXE instruction valid, one-hot op
//                       [0]mult [1]multu [2]div [3]divu [4]mthi [5]mtlo [6]mfhi [7]mflo
//   es_src1, es_src2    rs / rt operands (held by EXE while stalled)
//   flush               kill EXE instruction and in-flight work
//   es_stall            hold EXE (combinational)
//   mf_data             HI for mfhi, LO otherwise
//   hi, lo, busy        architectural registers, controller not idle
//   mul_*               multiplier operands / product
//   div_*               divider control, operands, quotient/remainder, done pulse
module hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic [7:0]  es_op,
  input  logic [31:0] es_src1,
  input  logic [31:0] es_src2,
  input  logic        flush,
  output logic        es_stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        div_start_q, div_start_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic is_mul, is_div, issue, done;

  always_comb begin
    is_mul = es_op[0] | es_op[1];
    is_div = es_op[2] | es_op[3];
    issue  = es_valid & ~flush & (state_q == IDLE);
    done   = ((state_q == MUL_WAIT) & (cnt_q == 3'd0)) |
             ((state_q == DIV_WAIT) & div_complete);

    state_d     = state_q;
    cnt_d       = cnt_q;
    div_start_d = div_start_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (flush) begin
      // Flush beats everything, including a same-cycle completion or mt*.
      state_d     = IDLE;
      cnt_d       = 3'd0;
      div_start_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            if (is_mul) begin
              // MUL_WAIT counts down to 0; the product is valid at cnt==0.
              cnt_d   = 3'(MUL_LAT - 1);
              state_d = MUL_WAIT;
            end else if (is_div) begin
              div_start_d = 1'b1;
              state_d     = DIV_WAIT;
            end else if (es_op[4]) begin
              hi_d = es_src1;
            end else if (es_op[5]) begin
              lo_d = es_src1;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_q == 3'd0) begin
            hi_d    = mul_result[63:32];
            lo_d    = mul_result[31:0];
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        DIV_WAIT: begin
          if (div_complete) begin
            lo_d        = div_s;
            hi_d        = div_r;
            div_start_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      div_start_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_start_q <= div_start_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // The issuing mul/div stays stalled until its own completion cycle.
  assign es_stall   = es_valid & ~flush & (is_mul | is_div) & ~done;
  assign mf_data    = es_op[6] ? hi_q : lo_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q != IDLE);
  assign mul_signed = es_op[0];
  assign mul_x      = es_src1;
  assign mul_y      = es_src2;
  assign div_start  = div_start_q;
  assign div_signed = es_op[2];
  assign div_x      = es_src1;
  assign div_y      = es_src2;

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset, es_valid, flush;
  logic [7:0]  es_op;
  logic [31:0] es_src1, es_src2;
  logic        es_stall, busy, mul_signed, div_start, div_signed, div_complete;
  logic [31:0] mf_data, hi, lo, mul_x, mul_y, div_x, div_y, div_s, div_r;
  logic [63:0] mul_result;

  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] ehi = 32'd0, elo = 32'd0;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .es_valid(es_valid), .es_op(es_op),
    .es_src1(es_src1), .es_src2(es_src2), .flush(flush),
    .es_stall(es_stall), .mf_data(mf_data), .hi(hi), .lo(lo), .busy(busy),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
  );

  // Reference arithmetic
  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (s) return longint'($signed(a)) * longint'($signed(b));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {remainder, quotient}; divide by zero yields all-ones quotient, remainder = dividend.
  function automatic logic [63:0] dref(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Pipelined multiplier model, LAT stages deep
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= prod(mul_signed, mul_x, mul_y);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[LAT-1];

  // Divider model: completes in the div_lat-th cycle that div_start is high
  int   div_lat = 33;
  int   dcnt = 0;
  logic late = 1'b0;
  logic [63:0] dres;
  always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
  assign dres         = dref(div_signed, div_x, div_y);
  assign div_s        = dres[31:0];
  assign div_r        = dres[63:32];
  assign div_complete = (div_start && dcnt == div_lat - 1) || late;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_arch(input string tag);
    chk32({tag, "_hi"}, hi, ehi);
    chk32({tag, "_lo"}, lo, elo);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic f);
    es_valid = v; es_op = op; es_src1 = a; es_src2 = b; flush = f;
    #1;
  endtask

  // fl_at: 0 = no flush, k = flush k cycles after issue
  task automatic do_mul(input logic s, input logic [31:0] a, input logic [31:0] b, input int fl_at);
    logic [7:0] op;
    op = s ? 8'h01 : 8'h02;
    drv(1'b1, op, a, b, 1'b0);
    chk1("mul_issue_stall", es_stall, 1'b1);
    chk1("mul_signed", mul_signed, s);
    for (int i = 1; i <= LAT; i++) begin
      step();
      if (i == fl_at) begin
        drv(1'b1, op, a, b, 1'b1);
        chk1("mul_flush_stall", es_stall, 1'b0);
        step();
        drv(1'b0, 8'h00, a, b, 1'b0);
        chk1("mul_flush_busy", busy, 1'b0);
        chk_arch("mul_flush");
        return;
      end
      chk1("mul_busy", busy, 1'b1);
      chk1("mul_stall", es_stall, i < LAT);
    end
    step();
    drv(1'b0, 8'h00, a, b, 1'b0);
    {ehi, elo} = prod(s, a, b);
    chk1("mul_done_busy", busy, 1'b0);
    chk_arch("mul");
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int fl_at);
    logic [7:0] op;
    op = s ? 8'h04 : 8'h08;
    div_lat = lat;
    drv(1'b1, op, a, b, 1'b0);
    chk1("div_issue_stall", es_stall, 1'b1);
    chk1("div_issue_start", div_start, 1'b0);
    chk1("div_signed", div_signed, s);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == fl_at) begin
        drv(1'b1, op, a, b, 1'b1);
        chk1("div_flush_stall", es_stall, 1'b0);
        step();
        drv(1'b0, 8'h00, a, b, 1'b0);
        chk1("div_flush_start", div_start, 1'b0);
        chk1("div_flush_busy", busy, 1'b0);
        chk_arch("div_flush");
        late = 1'b1;
        step();
        late = 1'b0;
        chk1("div_late_busy", busy, 1'b0);
        chk_arch("div_late");
        return;
      end
      chk1("div_start_hi", div_start, 1'b1);
      chk1("div_stall", es_stall, c != lat);
    end
    step();
    drv(1'b0, 8'h00, a, b, 1'b0);
    {ehi, elo} = dref(s, a, b);
    chk1("div_done_start", div_start, 1'b0);
    chk1("div_done_busy", busy, 1'b0);
    chk_arch("div");
  endtask

  task automatic do_mt(input logic to_hi, input logic [31:0] v, input logic f);
    drv(1'b1, to_hi ? 8'h10 : 8'h20, v, $urandom, f);
    chk1("mt_stall", es_stall, 1'b0);
    step();
    if (!f) begin
      if (to_hi) ehi = v; else elo = v;
    end
    chk_arch("mt");
  endtask

  task automatic do_mf(input logic from_hi);
    drv(1'b1, from_hi ? 8'h40 : 8'h80, $urandom, $urandom, 1'b0);
    chk1("mf_stall", es_stall, 1'b0);
    chk32("mf_data", mf_data, from_hi ? ehi : elo);
    step();
    chk_arch("mf");
  endtask

  task automatic idle();
    drv(1'b0, 8'h00, $urandom, $urandom, 1'b0);
    step();
  endtask

  initial begin
    int r;
    logic s;
    logic [31:0] a, b;

    // Reset state
    reset = 1'b1;
    drv(1'b0, 8'h00, 32'd0, 32'd0, 1'b0);
    step(); step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", es_stall, 1'b0);
    chk1("rst_div_start", div_start, 1'b0);
    chk32("rst_mf_data", mf_data, 32'd0);
    chk_arch("rst");
    drv(1'b1, 8'h01, 32'd3, 32'd4, 1'b0);
    chk1("rst_mul_stall", es_stall, 1'b1);
    drv(1'b0, 8'h00, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    step();

    // mult -3 * 5
    do_mul(1'b1, 32'hFFFFFFFD, 32'd5, 0);
    chk32("mult_hi_const", hi, 32'hFFFFFFFF);
    chk32("mult_lo_const", lo, 32'hFFFFFFF1);

    // multu 0xFFFFFFFF * 2 followed immediately by mfhi
    do_mul(1'b0, 32'hFFFFFFFF, 32'd2, 0);
    chk32("multu_hi_const", hi, 32'h00000001);
    chk32("multu_lo_const", lo, 32'hFFFFFFFE);
    do_mf(1'b1);

    // div -7 / 2 with a 33-cycle divider
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 33, 0);
    chk32("div_lo_const", lo, 32'hFFFFFFFD);
    chk32("div_hi_const", hi, 32'hFFFFFFFF);

    // divu 100 / 7 flushed 10 cycles after issue, then a stray complete
    do_div(1'b0, 32'd100, 32'd7, 33, 10);

    // mthi / mtlo / mflo, then mthi killed by flush
    do_mt(1'b1, 32'h12345678, 1'b0);
    do_mt(1'b0, 32'h9ABCDEF0, 1'b0);
    do_mf(1'b0);
    chk32("mflo_const", lo, 32'h9ABCDEF0);
    do_mt(1'b1, 32'hDEADBEEF, 1'b1);
    chk32("mthi_flush_const", hi, 32'h12345678);

    // Flush landing on the multiply completion cycle: no commit
    do_mul(1'b1, 32'h00001234, 32'h00005678, LAT);

    // Divide by zero takes the divider's output as is
    do_div(1'b0, 32'h0000ABCD, 32'd0, 5, 0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 1, 0);

    // Reset in the middle of a multiply (cnt == 1)
    drv(1'b1, 8'h02, 32'd7, 32'd9, 1'b0);
    step();
    chk1("rstmid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drv(1'b0, 8'h00, 32'd0, 32'd0, 1'b0);
    ehi = 32'd0; elo = 32'd0;
    chk1("rstmid_busy", busy, 1'b0);
    chk32("rstmid_mf", mf_data, 32'd0);
    chk_arch("rstmid");
    step();
    chk_arch("rstmid_after");

    // Randomized sequence against the reference model
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case (r)
        0: do_mul(s, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0);
        1: begin
          int lat;
          lat = $urandom_range(1, 12);
          do_div(s, a, b, lat, ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0);
        end
        2: do_mt(s, a, 1'b0);
        3: do_mf(s);
        4: idle();
        default: do_mt(s, a, 1'b1);
      endcase
    end
    idle();
    chk_arch("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing controller for the multiply/divide resources and the architectural HI/LO registers. It sits beside the ALU in the EXE stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EXE stage, drives the shared multiplier and the iterative divider, and stalls EXE while an operation is in flight. It commits results to HI/LO on completion and discards in-flight work when a later stage flushes the pipeline.

## Interface
- MUL_LAT, 2: multiplier pipeline latency in cycles, from operands applied to `mul_result` valid; legal range 1..7.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- es_valid  in  1  EXE stage holds a valid instruction.
- es_op  in  8  one-hot: [0] mult, [1] multu, [2] div, [3] divu, [4] mthi, [5] mtlo, [6] mfhi, [7] mflo.
- es_src1 / es_src2  in  32 each  rs / rt operands; held stable by EXE while `es_stall`=1.
- flush  in  1  exception/eret in a later stage; kills the EXE instruction and any in-flight operation.
- es_stall  out  1  hold EXE (combinational).
- mf_data  out  32  HI for mfhi, LO otherwise (combinational).
- hi / lo  out  32 each  architectural registers.
- busy  out  1  state != IDLE.
- mul_signed  out  1  `es_op[0]`.
- mul_x / mul_y  out  32 each  `es_src1` / `es_src2` passthrough.
- mul_result  in  64  {HI, LO} product.
- div_start  out  1  registered level; divider runs while high.
- div_signed  out  1  `es_op[2]`.
- div_x / div_y  out  32 each  operand passthrough.
- div_s / div_r  in  32 each  quotient / remainder.
- div_complete  in  1  one-cycle pulse; `div_s`/`div_r` valid in that cycle.

## Operation
- Issue condition: `issue = es_valid & ~flush & state==IDLE`.
- States: IDLE, MUL_WAIT, DIV_WAIT.
- IDLE with issue and mult/multu:
  - Load `cnt` with MUL_LAT-1, go to MUL_WAIT.
  - If MUL_LAT==1, complete in the next cycle directly with `cnt`=0.
- MUL_WAIT:
  - Decrement `cnt` each cycle.
  - In the cycle where `cnt`==0: `done`=1; HI<=`mul_result[63:32]`, LO<=`mul_result[31:0]` at that edge; go to IDLE.
- IDLE with issue and div/divu: set `div_start`<=1, go to DIV_WAIT.
- DIV_WAIT:
  - In the cycle where `div_complete`=1: `done`=1; LO<=`div_s`, HI<=`div_r`; `div_start`<=0; go to IDLE.
- Divide by zero: no trap. HI/LO take whatever `div_s`/`div_r` the divider returns.
- mthi / mtlo with issue: HI (or LO) <= `es_src1` at that edge; stays IDLE; no stall.
- mfhi / mflo:
  - `mf_data` reflects current HI/LO; no stall in IDLE.
  - EXE cannot hold a new instruction while busy, because `es_stall` holds the issuing one.
- Stall rule: `es_stall = es_valid & ~flush & (mul/div op) & ~done`.
  - `done` is combinational: (MUL_WAIT & `cnt`==0) | (DIV_WAIT & `div_complete`).
- Flush, any state:
  - Go to IDLE, `div_start`<=0, `cnt` cleared.
  - No HI/LO write, including a same-cycle `done` or mthi/mtlo.
  - `flush` has priority over every other event.
- `div_complete` arriving while not in DIV_WAIT: ignored.
- A `div_complete` that arrives after a flush is ignored as well.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, `cnt`=0, `div_start`=0.
  - Outputs under reset: `es_stall`=0 unless a mul/div is presented, `busy`=0, `mf_data`=0.
- Reset mid-operation: same as flush, and HI/LO are zeroed.
- Multiply issued in cycle T:
  - `es_stall`=1 in cycles T..T+MUL_LAT-1; 0 in cycle T+MUL_LAT.
  - HI/LO are updated at the end of T+MUL_LAT, so EXE occupancy is MUL_LAT+1 cycles.
- Divide issued in cycle T:
  - `div_start` goes high from T+1.
  - For `div_complete` in cycle C: `es_stall`=0 in C, HI/LO are updated at the end of C, and `div_start`=0 from C+1.
- Back-to-back: a mul/div in EXE at C+1 issues in C+1.
  - An mfhi at C+1 reads the new HI.
- `mul_x`/`mul_y` are not registered. The multiplier samples them every cycle, relying on EXE hold.

## Test plan
- mult `es_src1`=0xFFFFFFFD (-3), `es_src2`=5, MUL_LAT=2 -> `es_stall`=1 for 2 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` back to 0.
- multu 0xFFFFFFFF×2 followed immediately by mfhi -> HI=0x00000001, LO=0xFFFFFFFE; the mfhi cycle shows `mf_data`=0x00000001 with no stall.
- div -7/2 with a divider model that pulses complete after 33 cycles -> `div_start` high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; `es_stall` drops in the complete cycle.
- divu 100/7, then `flush` 10 cycles after issue -> `div_start` low next cycle; HI/LO unchanged; a late `div_complete` pulse is ignored.
- mthi 0x12345678, mtlo 0x9ABCDEF0, mflo -> no stall; `mf_data`=0x9ABCDEF0. mthi coinciding with `flush` -> HI unchanged.
- `reset` asserted mid-multiply at `cnt`=1 -> next cycle state=IDLE, HI=LO=0, `busy`=0, no commit.
